// File: rtl/img_pkg.sv
// Shared image-stream types and small arithmetic helpers for the Y-channel chain.
package img_pkg;
    typedef logic [7:0] pixel_t;

    localparam int SOBEL_LAT = 4;

    typedef struct packed {
        logic vsync;
        logic herf;
    } img_sync_t;

    // a + 2b + c on 8-bit pixels; max 1020 fits in 10 bits
    function automatic logic [9:0] wsum(input pixel_t a, input pixel_t b, input pixel_t c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    function automatic logic [10:0] abs11(input logic signed [10:0] v);
        return v[10] ? 11'(-v) : 11'(v);
    endfunction
endpackage

// File: rtl/matrix_3x3_gen.sv
// Two line buffers plus a 3x3 shift window over the luma stream; also tracks
// row/column position so the consumer can mask borders and stale buffer data.
module matrix_3x3_gen
    import img_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          per_img_vsync,
    input  logic                          per_img_herf,
    input  pixel_t                        per_img_Y,
    output pixel_t                        p11, p12, p13,
    output pixel_t                        p21, p22, p23,
    output pixel_t                        p31, p32, p33,
    output logic                          window_valid,
    output logic [$clog2(IMG_HEIGHT)-1:0] row_cnt,
    output logic [$clog2(IMG_WIDTH)-1:0]  col_cnt,
    output img_sync_t                     sync_d
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    pixel_t lb0 [IMG_WIDTH];
    pixel_t lb1 [IMG_WIDTH];
    pixel_t lb0_q, lb1_q;

    logic vs_prev, hf_prev, armed, col_ovf;
    logic rise, frame_ok, hf_eff, pix_ok;

    // vs_prev resets high so a frame already in flight at reset release is not
    // mistaken for a fresh vsync rising edge.
    assign rise     = per_img_vsync & ~vs_prev;
    assign frame_ok = per_img_vsync & (armed | rise);
    assign hf_eff   = per_img_herf & frame_ok;
    assign pix_ok   = hf_eff & ~col_ovf;

    assign lb0_q = lb0[col_cnt];
    assign lb1_q = lb1[col_cnt];

    always_ff @(posedge clk) begin
        if (pix_ok) begin
            lb1[col_cnt] <= lb0_q;
            lb0[col_cnt] <= per_img_Y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_prev      <= 1'b1;
            hf_prev      <= 1'b0;
            armed        <= 1'b0;
            col_cnt      <= '0;
            col_ovf      <= 1'b0;
            row_cnt      <= '0;
            window_valid <= 1'b0;
            sync_d       <= '0;
            {p11, p12, p13, p21, p22, p23, p31, p32, p33} <= '0;
        end else begin
            vs_prev      <= per_img_vsync;
            hf_prev      <= hf_eff;
            armed        <= armed | rise;
            sync_d.vsync <= frame_ok;
            sync_d.herf  <= hf_eff;

            if (hf_eff) begin
                if (col_cnt == CW'(IMG_WIDTH - 1)) col_ovf <= 1'b1;
                else                               col_cnt <= col_cnt + 1'b1;
            end else begin
                col_cnt <= '0;
                col_ovf <= 1'b0;
            end

            if (rise)
                row_cnt <= '0;
            else if (hf_prev && !hf_eff && row_cnt != RW'(IMG_HEIGHT - 1))
                row_cnt <= row_cnt + 1'b1;

            window_valid <= pix_ok && (row_cnt >= RW'(2)) && (col_cnt >= CW'(2));

            if (hf_eff) begin
                p11 <= p12;  p12 <= p13;  p13 <= lb1_q;
                p21 <= p22;  p22 <= p23;  p23 <= lb0_q;
                p31 <= p32;  p32 <= p33;  p33 <= per_img_Y;
            end
        end
    end
endmodule

// File: rtl/y_sobel_edge.sv
// Sobel |Gx|+|Gy| on the luma stream: saturated 8-bit gradient plus a thresholded
// edge bit, framing delayed by SOBEL_LAT cycles.
module y_sobel_edge
    import img_pkg::*;
#(
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480,
    parameter int EDGE_THRESH = 80
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       per_img_vsync,
    input  logic       per_img_herf,
    input  logic [7:0] per_img_Y,
    output logic       post_img_vsync,
    output logic       post_img_herf,
    output logic [7:0] post_img_grad,
    output logic       post_img_bit
);
    pixel_t p11, p12, p13, p21, p22, p23, p31, p32, p33;
    logic window_valid;
    logic [$clog2(IMG_HEIGHT)-1:0] row_cnt;
    logic [$clog2(IMG_WIDTH)-1:0]  col_cnt;
    img_sync_t sync1;
    logic unused_cnt;

    matrix_3x3_gen #(.IMG_WIDTH(IMG_WIDTH), .IMG_HEIGHT(IMG_HEIGHT)) u_matrix (
        .clk(clk), .rst_n(rst_n),
        .per_img_vsync(per_img_vsync), .per_img_herf(per_img_herf), .per_img_Y(per_img_Y),
        .p11(p11), .p12(p12), .p13(p13),
        .p21(p21), .p22(p22), .p23(p23),
        .p31(p31), .p32(p32), .p33(p33),
        .window_valid(window_valid), .row_cnt(row_cnt), .col_cnt(col_cnt),
        .sync_d(sync1)
    );

    assign unused_cnt = ^{row_cnt, col_cnt};

    img_sync_t sync_pipe [2:SOBEL_LAT];
    logic [3:2] vld_pipe;
    logic [9:0] gx_pos, gx_neg, gy_pos, gy_neg;
    logic signed [10:0] gx, gy;
    logic [10:0] mag;

    assign gx = $signed({1'b0, gx_pos}) - $signed({1'b0, gx_neg});
    assign gy = $signed({1'b0, gy_pos}) - $signed({1'b0, gy_neg});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 2; i <= SOBEL_LAT; i++) sync_pipe[i] <= '0;
            vld_pipe      <= '0;
            gx_pos        <= '0;
            gx_neg        <= '0;
            gy_pos        <= '0;
            gy_neg        <= '0;
            mag           <= '0;
            post_img_grad <= '0;
            post_img_bit  <= 1'b0;
        end else begin
            sync_pipe[2] <= sync1;
            for (int i = 3; i <= SOBEL_LAT; i++) sync_pipe[i] <= sync_pipe[i-1];
            vld_pipe <= {vld_pipe[2], window_valid};

            gx_pos <= wsum(p13, p23, p33);
            gx_neg <= wsum(p11, p21, p31);
            gy_pos <= wsum(p31, p32, p33);
            gy_neg <= wsum(p11, p12, p13);

            mag <= abs11(gx) + abs11(gy);

            // border, overflow and blanking pixels all carry vld_pipe=0
            post_img_grad <= !vld_pipe[3]   ? 8'h00 :
                             (mag > 11'd255) ? 8'hFF : mag[7:0];
            post_img_bit  <= vld_pipe[3] && (mag >= 11'(EDGE_THRESH));
        end
    end

    assign post_img_vsync = sync_pipe[SOBEL_LAT].vsync;
    assign post_img_herf  = sync_pipe[SOBEL_LAT].herf;
endmodule

// File: tb/tb_y_sobel_edge.sv
// Directed bench: small frames through two instances (threshold 80 and 8), captured
// outputs compared against a direct 2D Sobel model and a table of hand-computed points.
module tb_y_sobel_edge;
    localparam int W = 16;
    localparam int H = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic per_img_vsync = 1'b0, per_img_herf = 1'b0;
    logic [7:0] per_img_Y = 8'h00;
    logic vs_a, hf_a, bit_a, vs_b, hf_b, bit_b;
    logic [7:0] grad_a, grad_b;

    y_sobel_edge #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .EDGE_THRESH(80)) dut_a (
        .clk(clk), .rst_n(rst_n), .per_img_vsync(per_img_vsync), .per_img_herf(per_img_herf),
        .per_img_Y(per_img_Y), .post_img_vsync(vs_a), .post_img_herf(hf_a),
        .post_img_grad(grad_a), .post_img_bit(bit_a));

    y_sobel_edge #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .EDGE_THRESH(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .per_img_vsync(per_img_vsync), .per_img_herf(per_img_herf),
        .per_img_Y(per_img_Y), .post_img_vsync(vs_b), .post_img_herf(hf_b),
        .post_img_grad(grad_b), .post_img_bit(bit_b));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0, checks = 0;
    int img [H][W];
    int cg_a [6][H][W], cb_a [6][H][W], cg_b [6][H][W], cb_b [6][H][W];
    int cur_pat = 5;
    int orow = 0, ocol = 0, hcnt = 0;
    logic vs_q = 1'b0, hf_q = 1'b0;
    int t_in = -1, t_out = -1, t_vin = -1, t_vout = -1;
    int rst_bad = 0, idle_bad = 0, fr_bad = 0, dead_herf = 0, dead_vs = 0;
    logic dead = 1'b0;

    always @(negedge clk) begin
        if (!rst_n && (vs_a || hf_a || grad_a != 0 || bit_a)) rst_bad++;
        if (!hf_a && (grad_a != 0 || bit_a || grad_b != 0 || bit_b)) idle_bad++;
        if (vs_a != vs_b || hf_a != hf_b) fr_bad++;
        if (dead && hf_a) dead_herf++;
        if (dead && vs_a) dead_vs++;
        if (per_img_herf && t_in < 0) t_in = cyc;
        if (hf_a && t_out < 0) t_out = cyc;
        if (per_img_vsync && t_vin < 0) t_vin = cyc;
        if (vs_a && t_vout < 0) t_vout = cyc;
        if (vs_a && !vs_q) begin orow = 0; ocol = 0; hcnt = 0; end
        if (hf_a) begin
            if (orow < H && ocol < W) begin
                cg_a[cur_pat][orow][ocol] = grad_a; cb_a[cur_pat][orow][ocol] = bit_a;
                cg_b[cur_pat][orow][ocol] = grad_b; cb_b[cur_pat][orow][ocol] = bit_b;
            end
            ocol++; hcnt++;
        end else if (hf_q) begin
            orow++; ocol = 0;
        end
        vs_q = vs_a; hf_q = hf_a;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc1(input logic vs, input logic hf, input int y);
        per_img_vsync = vs; per_img_herf = hf; per_img_Y = 8'(y);
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input int pat, input int rst_row);
        cur_pat = pat;
        repeat (2) cyc1(1'b0, 1'b0, 0);
        dead = 1'b0;
        repeat (2) cyc1(1'b1, 1'b0, 0);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == rst_row && c == 5) begin rst_n = 1'b0; dead = 1'b1; end
                if (r == rst_row && c == 8) rst_n = 1'b1;
                cyc1(1'b1, 1'b1, img[r][c]);
            end
            repeat (3) cyc1(1'b1, 1'b0, 0);
        end
        repeat (6) cyc1(1'b1, 1'b0, 0);
        cyc1(1'b0, 1'b0, 0);
    endtask

    function automatic void model(input int r, input int c, input int thr,
                                  output int g, output int b);
        int gx, gy, m;
        if (r < 2 || c < 2) begin g = 0; b = 0; return; end
        gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
           - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
        gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c])
           - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
        m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        g = m > 255 ? 255 : m;
        b = (m >= thr) ? 1 : 0;
    endfunction

    task automatic cmp_frame(input string name, input int pat);
        int bad = 0;
        int g, b;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                model(r, c, 80, g, b);
                if (cg_a[pat][r][c] != g || cb_a[pat][r][c] != b) bad++;
                model(r, c, 8, g, b);
                if (cg_b[pat][r][c] != g || cb_b[pat][r][c] != b) bad++;
            end
        chk({name, " pixel mismatches"}, bad, 0);
        chk({name, " herf count"}, hcnt, W*H);
    endtask

    typedef struct {
        int pat; int inst; int r; int c; int grad; int bit_;
    } vec_t;
    vec_t vec [16];

    initial begin
        int g, b;
        vec[0]  = '{0, 0, 5, 7,   0, 0};
        vec[1]  = '{0, 0, 0, 0,   0, 0};
        vec[2]  = '{1, 0, 2, 8, 255, 1};
        vec[3]  = '{1, 0, 7, 9, 255, 1};
        vec[4]  = '{1, 0, 4, 7,   0, 0};
        vec[5]  = '{1, 0, 4, 10,  0, 0};
        vec[6]  = '{1, 0, 1, 8,   0, 0};
        vec[7]  = '{2, 0, 3, 5,   8, 0};
        vec[8]  = '{2, 1, 3, 5,   8, 1};
        vec[9]  = '{2, 1, 7, 15,  8, 1};
        vec[10] = '{2, 1, 3, 1,   0, 0};
        vec[11] = '{2, 1, 0, 5,   0, 0};
        vec[12] = '{3, 0, 2, 2,   0, 0};
        vec[13] = '{3, 0, 7, 15,  0, 0};
        vec[14] = '{3, 0, 0, 0,   0, 0};
        vec[15] = '{3, 1, 4, 8,   0, 0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset vsync", vs_a, 0);
        chk("reset herf", hf_a, 0);
        chk("reset grad", grad_a, 0);
        chk("reset bit", bit_a, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 8'h80;
        send_frame(0, -1);
        cmp_frame("flat", 0);
        chk("herf latency", t_out - t_in, 4);
        chk("vsync latency", t_vout - t_vin, 4);

        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = (c < W/2) ? 0 : 255;
        send_frame(1, -1);
        cmp_frame("vstep", 1);

        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = c;
        send_frame(2, -1);
        cmp_frame("ramp", 2);

        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 255;
        send_frame(5, -1);
        cmp_frame("white", 5);
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 0;
        send_frame(3, -1);
        cmp_frame("black after white", 3);

        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = $urandom_range(0, 255);
        send_frame(5, 4);
        chk("outputs nonzero during reset", rst_bad, 0);
        chk("herf after reset before new frame", dead_herf, 0);
        chk("vsync after reset before new frame", dead_vs, 0);

        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = $urandom_range(0, 255);
        send_frame(4, -1);
        cmp_frame("random after reset", 4);

        for (int i = 0; i < 16; i++) begin
            g = vec[i].inst ? cg_b[vec[i].pat][vec[i].r][vec[i].c] : cg_a[vec[i].pat][vec[i].r][vec[i].c];
            b = vec[i].inst ? cb_b[vec[i].pat][vec[i].r][vec[i].c] : cb_a[vec[i].pat][vec[i].r][vec[i].c];
            chk($sformatf("vec%0d grad", i), g, vec[i].grad);
            chk($sformatf("vec%0d bit", i), b, vec[i].bit_);
        end

        chk("grad/bit nonzero with herf low", idle_bad, 0);
        chk("framing differs between instances", fr_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
